// File: rtl/bfu_mont_pipe.sv
// rtl/bfu_mont_pipe.sv - multi-lane four-stage Montgomery butterfly pipeline for NTT/INTT
//
// Purpose:
//   LANES independent Montgomery butterflies that share one control path.
//   The mode is chosen per transaction: NTT (Cooley-Tukey) or INTT (Gentleman-Sande).
//     NTT : m = mont(b*tw);  o_a = a + m;  o_b = a - m
//     INTT: o_a = a + b;     o_b = mont((b - a)*tw)
//   mont(x) = (x - t*Q) >>> DATA_W, where t = signed low DATA_W bits of x*QINV.
//   Latency is 4 cycles. Throughput is 1 transaction per cycle. Backpressure stalls the whole pipe.
//
// Optional build macro:
//   BFU_MONT_FREEZE_EN - stage 4 maps each output into [0, Q) with one conditional add/subtract of Q.
//
// Ports:
//   i_clk, i_rst        clock; asynchronous active-high reset
//   i_valid / o_ready   input handshake; o_ready = i_ready || !o_valid
//   i_intt              per-transaction mode (0 = NTT, 1 = INTT)
//   i_a, i_b, i_twiddle lane k at [k*DATA_W +: DATA_W], signed; twiddle is in the Montgomery domain
//   o_valid / i_ready   output handshake
//   o_a, o_b            lane-packed signed results
//   o_busy              at least one stage holds a valid transaction

module bfu_mont_pipe #(
  parameter int          LANES  = 1,
  parameter int          DATA_W = 32,
  parameter int unsigned Q      = 32'd8380417,
  parameter int unsigned QINV   = 32'd58728449
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_intt,
  input  logic [LANES*DATA_W-1:0] i_a,
  input  logic [LANES*DATA_W-1:0] i_b,
  input  logic [LANES*DATA_W-1:0] i_twiddle,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [LANES*DATA_W-1:0] o_a,
  output logic [LANES*DATA_W-1:0] o_b,
  output logic                    o_busy
);

  localparam int PW = 2 * DATA_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [PW-1:0]     dword_t;

  localparam dword_t Q_P    = dword_t'(Q);
  localparam word_t  Q_D    = word_t'(Q);
  localparam word_t  QINV_D = word_t'(QINV);

  function automatic dword_t sext(input word_t v);
    return {{DATA_W{v[DATA_W-1]}}, v};
  endfunction

`ifdef BFU_MONT_FREEZE_EN
  // Fold a value in (-Q, 2Q) into [0, Q) with one correction.
  function automatic word_t freeze(input word_t v);
    if (v[DATA_W-1]) begin
      return v + Q_D;
    end else if (v >= Q_D) begin
      return v - Q_D;
    end else begin
      return v;
    end
  endfunction
`endif

  logic en;

  // Per-stage valid and mode bits
  logic s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q;
  logic s1_intt_q, s2_intt_q, s3_intt_q;

  // S1: x is the value that goes straight to the output adder.
  //     y is the multiplicand that goes into the Montgomery product.
  logic [LANES-1:0][DATA_W-1:0] s1_x_d, s1_x_q;
  logic [LANES-1:0][DATA_W-1:0] s1_y_d, s1_y_q;
  logic [LANES-1:0][DATA_W-1:0] s1_tw_q;

  // S2: full-width product
  logic [LANES-1:0][PW-1:0]     s2_prod_d, s2_prod_q;
  logic [LANES-1:0][DATA_W-1:0] s2_x_q;

  // S3: Montgomery quotient t, with the product carried alongside it
  logic [LANES-1:0][DATA_W-1:0] s3_t_d, s3_t_q;
  logic [LANES-1:0][PW-1:0]     s3_prod_q;
  logic [LANES-1:0][DATA_W-1:0] s3_x_q;

  // S4: registered outputs
  logic [LANES-1:0][DATA_W-1:0] s4_r;
  logic [LANES-1:0][DATA_W-1:0] s4_a_raw, s4_b_raw;
  logic [LANES-1:0][DATA_W-1:0] s4_a_d, s4_a_q;
  logic [LANES-1:0][DATA_W-1:0] s4_b_d, s4_b_q;

  // A single enable moves every stage together. The pipe keeps moving while S4 is empty,
  // so bubbles are squeezed out when downstream stalls.
  assign en      = i_ready | ~s4_vld_q;
  assign o_ready = en;
  assign o_valid = s4_vld_q;
  assign o_busy  = s1_vld_q | s2_vld_q | s3_vld_q | s4_vld_q;
  assign o_a     = s4_a_q;
  assign o_b     = s4_b_q;

  // S1 pre-add/sub.
  //   NTT : x = a,     y = b
  //   INTT: x = a + b, y = b - a
  always_comb begin
    s1_x_d = '0;
    s1_y_d = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_intt) begin
        s1_x_d[k] = i_a[k*DATA_W +: DATA_W] + i_b[k*DATA_W +: DATA_W];
        s1_y_d[k] = i_b[k*DATA_W +: DATA_W] - i_a[k*DATA_W +: DATA_W];
      end else begin
        s1_x_d[k] = i_a[k*DATA_W +: DATA_W];
        s1_y_d[k] = i_b[k*DATA_W +: DATA_W];
      end
    end
  end

  // S2 signed product. Both operands are sign-extended to PW bits,
  // so the low PW bits of the unsigned multiply equal the signed product.
  always_comb begin
    s2_prod_d = '0;
    for (int k = 0; k < LANES; k++) begin
      s2_prod_d[k] = sext(s1_y_q[k]) * sext(s1_tw_q[k]);
    end
  end

  // S3 quotient. Only the low DATA_W bits of product*QINV are needed,
  // so only the low half of the product takes part.
  always_comb begin
    s3_t_d = '0;
    for (int k = 0; k < LANES; k++) begin
      s3_t_d[k] = s2_prod_q[k][DATA_W-1:0] * QINV_D;
    end
  end

  // S4 reduction and final add/sub.
  // The low half of (prod - t*Q) is zero by construction, so the upper half is the exact result.
  always_comb begin
    s4_r     = '0;
    s4_a_raw = '0;
    s4_b_raw = '0;
    s4_a_d   = '0;
    s4_b_d   = '0;
    for (int k = 0; k < LANES; k++) begin
      s4_r[k] = word_t'((s3_prod_q[k] - sext(s3_t_q[k]) * Q_P) >> DATA_W);
      if (s3_intt_q) begin
        s4_a_raw[k] = s3_x_q[k];
        s4_b_raw[k] = s4_r[k];
      end else begin
        s4_a_raw[k] = s3_x_q[k] + s4_r[k];
        s4_b_raw[k] = s3_x_q[k] - s4_r[k];
      end
`ifdef BFU_MONT_FREEZE_EN
      s4_a_d[k] = freeze(s4_a_raw[k]);
      s4_b_d[k] = freeze(s4_b_raw[k]);
`else
      s4_a_d[k] = s4_a_raw[k];
      s4_b_d[k] = s4_b_raw[k];
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
      s4_vld_q  <= 1'b0;
      s1_intt_q <= 1'b0;
      s2_intt_q <= 1'b0;
      s3_intt_q <= 1'b0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_tw_q   <= '0;
      s2_prod_q <= '0;
      s2_x_q    <= '0;
      s3_t_q    <= '0;
      s3_prod_q <= '0;
      s3_x_q    <= '0;
      s4_a_q    <= '0;
      s4_b_q    <= '0;
    end else if (en) begin
      // When en is high and i_valid is low, a bubble enters S1.
      s1_vld_q  <= i_valid;
      s1_intt_q <= i_intt;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_tw_q   <= i_twiddle;

      s2_vld_q  <= s1_vld_q;
      s2_intt_q <= s1_intt_q;
      s2_prod_q <= s2_prod_d;
      s2_x_q    <= s1_x_q;

      s3_vld_q  <= s2_vld_q;
      s3_intt_q <= s2_intt_q;
      s3_t_q    <= s3_t_d;
      s3_prod_q <= s2_prod_q;
      s3_x_q    <= s2_x_q;

      s4_vld_q  <= s3_vld_q;
      s4_a_q    <= s4_a_d;
      s4_b_q    <= s4_b_d;
    end
  end

endmodule

// File: tb/tb_bfu_mont_pipe.sv
// tb/tb_bfu_mont_pipe.sv - directed plus random self-checking bench for bfu_mont_pipe (LANES=4)

module tb_bfu_mont_pipe;

  localparam int L      = 4;
  localparam int W      = 32;
  localparam int Q      = 8380417;
  localparam int QINV   = 58728449;
  localparam int R_MODQ = 4193792;

  logic             clk;
  logic             i_rst;
  logic             i_valid;
  logic             o_ready;
  logic             i_intt;
  logic [L*W-1:0]   i_a, i_b, i_tw;
  logic             o_valid;
  logic             i_ready;
  logic [L*W-1:0]   o_a, o_b;
  logic             o_busy;
  logic             rdy_man, rdy_rand, rand_mode;

  assign i_ready = rand_mode ? rdy_rand : rdy_man;

  bfu_mont_pipe #(.LANES(L), .DATA_W(W), .Q(Q), .QINV(QINV)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_intt(i_intt),
    .i_a(i_a), .i_b(i_b), .i_twiddle(i_tw), .o_valid(o_valid), .i_ready(i_ready),
    .o_a(o_a), .o_b(o_b), .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   beats  = 0;
  int   ta[L], tbv[L], ttw[L];

  // Reference arithmetic: 32-bit int wraps, and longint holds the full products.
  function automatic int mont(longint x);
    int     t;
    longint d;
    t = int'(x) * QINV;
    d = x - longint'(t) * longint'(Q);
    return int'(d >>> 32);
  endfunction

  function automatic int fz(int v);
`ifdef BFU_MONT_FREEZE_EN
    if (v < 0) return v + Q;
    if (v >= Q) return v - Q;
`endif
    return v;
  endfunction

  function automatic exp_t model(input logic intt);
    exp_t e;
    int   m, ea, eb;
    for (int k = 0; k < L; k++) begin
      if (!intt) begin
        m  = mont(longint'(tbv[k]) * longint'(ttw[k]));
        ea = ta[k] + m;
        eb = ta[k] - m;
      end else begin
        ea = ta[k] + tbv[k];
        eb = mont(longint'(tbv[k] - ta[k]) * longint'(ttw[k]));
      end
      e.a[k*W +: W] = fz(ea);
      e.b[k*W +: W] = fz(eb);
    end
    return e;
  endfunction

  function automatic int rnd();
    return int'($urandom_range(0, 2*Q-2)) - (Q - 1);
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(expv));
    end
  endtask

  task automatic rnd_ops();
    for (int k = 0; k < L; k++) begin
      ta[k]  = rnd();
      tbv[k] = rnd();
      ttw[k] = rnd();
    end
  endtask

  task automatic drive_inputs(input logic intt);
    i_intt = intt;
    for (int k = 0; k < L; k++) begin
      i_a[k*W +: W]  = ta[k];
      i_b[k*W +: W]  = tbv[k];
      i_tw[k*W +: W] = ttw[k];
    end
  endtask

  // Present one transaction and hold it until it is accepted, within a cycle budget.
  task automatic send(input logic intt);
    int n;
    n = 0;
    drive_inputs(intt);
    i_valid = 1'b1;
    @(negedge clk);
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (o_ready) begin
      exp_q.push_back(model(intt));
    end else begin
      n_cmp++;
      n_fail++;
      $error("FAIL send_timeout observed=o_ready 0 expected=1");
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_valid(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      @(posedge clk);
      #1;
      if (o_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $error("FAIL wait_valid_timeout observed=0 expected=1");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk32("drain_empty", exp_q.size(), 0);
  endtask

  // Scoreboard: compare every beat transferred downstream against the oldest expected result.
  always @(negedge clk) begin
    if (!i_rst && o_valid && i_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $error("FAIL unexpected_beat observed=a:%h expected=no beat", o_a);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        beats++;
        assert (o_a === e.a && o_b === e.b) else begin
          n_fail++;
          $error("FAIL beat_data observed=a:%h b:%h expected=a:%h b:%h", o_a, o_b, e.a, e.b);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rdy_rand = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int exp_l[L];
    exp_t h;

    i_rst = 1'b0; i_valid = 1'b0; i_intt = 1'b0;
    i_a = '0; i_b = '0; i_tw = '0;
    rdy_man = 1'b0; rdy_rand = 1'b1; rand_mode = 1'b0;

    // Reset state
    #1 i_rst = 1'b1;
    #2;
    chk32("rst_valid", 32'(o_valid), 0);
    chk32("rst_busy",  32'(o_busy), 0);
    chk32("rst_oa0",   o_a[31:0], 0);
    chk32("rst_ob0",   o_b[31:0], 0);
    chk32("rst_ready", 32'(o_ready), 1);
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
    rdy_man = 1'b1;

    // NTT directed case with latency check
    rnd_ops();
    ta[0] = 100; tbv[0] = 5; ttw[0] = R_MODQ;
    send(1'b0);
    @(posedge clk); #1; chk32("lat_e1_valid", 32'(o_valid), 0);
    @(posedge clk); #1; chk32("lat_e2_valid", 32'(o_valid), 0);
    @(posedge clk); #1; chk32("lat_e3_valid", 32'(o_valid), 1);
    chk32("ntt_oa", o_a[31:0], 105);
    chk32("ntt_ob", o_b[31:0], 95);
    drain();

    // INTT directed case
    rnd_ops();
    ta[0] = 100; tbv[0] = 30; ttw[0] = R_MODQ;
    send(1'b1);
    wait_valid(8);
    chk32("intt_oa", o_a[31:0], 130);
`ifdef BFU_MONT_FREEZE_EN
    chk32("intt_ob", o_b[31:0], 8380347);
`else
    chk32("intt_ob", o_b[31:0], -70);
`endif
    drain();

    // Four lanes, NTT: o_a equals b because a = 0 and tw = R mod Q
    for (int k = 0; k < L; k++) begin
      ta[k] = 0;
      ttw[k] = R_MODQ;
    end
    tbv[0] = -7; tbv[1] = 1; tbv[2] = 2; tbv[3] = 3;
`ifdef BFU_MONT_FREEZE_EN
    exp_l[0] = 8380410;
`else
    exp_l[0] = -7;
`endif
    exp_l[1] = 1; exp_l[2] = 2; exp_l[3] = 3;
    send(1'b0);
    wait_valid(8);
    for (int k = 0; k < L; k++) chk32($sformatf("lanes_oa%0d", k), o_a[k*W +: W], exp_l[k]);
    drain();

    // Eight back-to-back transactions with alternating mode
    b0 = beats;
    for (int i = 0; i < 8; i++) begin
      rnd_ops();
      send(1'((i % 2) != 0));
    end
    drain();
    chk32("b2b_beats", beats - b0, 8);

    // Backpressure with a full pipe and a fifth transaction held at the input
    b0 = beats;
    rdy_man = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rnd_ops();
      send(1'((i % 2) == 0));
    end
    rnd_ops();
    drive_inputs(1'b1);
    i_valid = 1'b1;
    h = exp_q[0];
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk32("bp_ready", 32'(o_ready), 0);
      chk32("bp_valid", 32'(o_valid), 1);
      chk32("bp_busy",  32'(o_busy), 1);
      n_cmp++;
      assert (o_a === h.a && o_b === h.b) else begin
        n_fail++;
        $error("FAIL bp_hold observed=a:%h expected=a:%h", o_a, h.a);
      end
    end
    rdy_man = 1'b1;
    #1;
    chk32("bp_release_ready", 32'(o_ready), 1);
    exp_q.push_back(model(1'b1));
    @(posedge clk); #1;
    i_valid = 1'b0;
    drain();
    chk32("bp_beats", beats - b0, 5);

    // Random traffic with random downstream readiness
    b0 = beats;
    rand_mode = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rnd_ops();
      send(1'($urandom_range(0, 1)));
    end
    rand_mode = 1'b0;
    rdy_man = 1'b1;
    drain();
    chk32("rand_beats", beats - b0, 40);

    // Reset with three transactions in flight and S4 stalled
    rdy_man = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rnd_ops();
      send(1'b0);
    end
    @(posedge clk); #1;
    chk32("pre_rst_valid", 32'(o_valid), 1);
    chk32("pre_rst_busy",  32'(o_busy), 1);
    #2 i_rst = 1'b1;
    #1;
    chk32("async_rst_valid", 32'(o_valid), 0);
    chk32("async_rst_busy",  32'(o_busy), 0);
    chk32("async_rst_oa",    o_a[31:0], 0);
    chk32("async_rst_ob",    o_b[31:0], 0);
    exp_q.delete();
    @(posedge clk); #1;
    i_rst = 1'b0;
    #1;
    chk32("post_rst_ready", 32'(o_ready), 1);
    rdy_man = 1'b1;
    b0 = beats;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk32("post_rst_no_stale", 32'(o_valid), 0);
    end
    chk32("post_rst_beats", beats - b0, 0);

    // Traffic still flows after the reset
    rnd_ops();
    send(1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bfu_mont_pipe.md
Name: bfu_mont_pipe

Overview:
- Parametrised, multi-lane Montgomery butterfly unit for the ML-DSA NTT/INTT datapath; successor to the fixed single-lane butterfly.
- Modulus, Montgomery constant, data width and lane count are parameters.
- NTT/INTT mode is carried per transaction rather than being a static input.
- Fixed-latency pipeline with valid/ready handshake and full backpressure; sits between the coefficient-RAM read port and the write-back buffer of the NTT controller.

Parameters:
- LANES, 1, number of independent butterflies processed in parallel.
- DATA_W, 32, signed coefficient/twiddle width; Montgomery radix R = 2^DATA_W.
- Q, 8380417, modulus.
- QINV, 58728449, Q^-1 mod 2^DATA_W.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  input transaction valid.
- o_ready  out  1  unit can accept an input this cycle.
- i_intt  in  1  per-transaction mode: 0 = NTT (Cooley-Tukey), 1 = INTT (Gentleman-Sande).
- i_a  in  LANES*DATA_W  signed a operands; lane k occupies bits [k*DATA_W +: DATA_W].
- i_b  in  LANES*DATA_W  signed b operands.
- i_twiddle  in  LANES*DATA_W  signed twiddles, Montgomery domain.
- o_valid  out  1  output transaction valid.
- i_ready  in  1  downstream accepts output.
- o_a  out  LANES*DATA_W  signed a results.
- o_b  out  LANES*DATA_W  signed b results.
- o_busy  out  1  at least one pipeline stage holds a valid transaction.

Behaviour:
- mont(x), x of width 2*DATA_W: t = low DATA_W bits of (x*QINV), interpreted as signed; r = (x - t*Q) >>> DATA_W. r is in (-Q, Q).
- NTT: m = mont(b*tw); o_a = a + m; o_b = a - m.
- INTT: o_a = a + b; o_b = mont((b - a)*tw). No conditional correction unless the optional feature is enabled.
- Operand range: inputs lie in (-Q, Q). Sums are not range-checked. The caller guarantees intermediate values fit in DATA_W. Wrap in DATA_W is the defined behaviour if violated.
- Pipeline stages (all registers, each with a valid bit):
  - S1: pre-add/sub, twiddle and mode capture.
  - S2: product b*tw, 2*DATA_W wide.
  - S3: t = product*QINV truncated; product forwarded.
  - S4: reduction, final add/sub, registered outputs.
- Mode bit travels with its transaction through all stages. Lanes share control and are fully independent in data.
- Handshake:
  - Input is accepted on a rising edge with i_valid && o_ready.
  - Output is transferred on a rising edge with o_valid && i_ready.
  - Stage enable en = i_ready || !o_valid. All stages advance together when en = 1.
  - o_ready = en, combinational from i_ready and the S4 valid bit.
- Latency: accepted at edge E0 -> o_valid and data present after edge E3. That is 4 cycles, and throughput is 1 per cycle while i_ready = 1.
- Stall: when o_valid && !i_ready, every stage register holds. o_a, o_b and o_valid stay stable; o_ready = 0. No drop or duplication.
- Bubbles: with en = 1 and i_valid = 0, a bubble (valid = 0) enters S1. Data registers may update; only valid bits are meaningful.
- Ordering: strictly FIFO; output order equals accept order.
- Reset, async, active-high, including mid-operation:
  - All valid bits clear immediately, so o_valid = 0 and o_busy = 0.
  - o_a = 0 and o_b = 0; data registers clear to 0.
  - In-flight transactions are discarded. o_ready = 1 from the first cycle after release.
- o_busy = OR of the S1..S4 valid bits.

Optional Feature:
- Macro: BFU_MONT_FREEZE_EN.
- When defined, S4 maps each output into [0, Q): add Q if negative, subtract Q if >= Q, applied once. Latency is unchanged at 4.
- When undefined, outputs are raw signed values as above.

Test Plan:
- NTT, LANES=1: a=100, b=5, tw=4193792 (R mod Q) -> o_a=105, o_b=95, o_valid exactly 4 cycles after accept.
- INTT: a=100, b=30, tw=4193792 -> o_a=130, o_b=-70 (freeze enabled: o_b=8380347).
- 8 back-to-back transactions, alternating i_intt, i_ready=1 -> 8 consecutive o_valid beats, in order, each with correct per-transaction mode.
- Backpressure: i_ready=0 for 3 cycles with a full pipe -> o_ready=0, o_a/o_b/o_valid stable throughout; afterwards all transactions delivered once, in order.
- Reset asserted with 3 transactions in flight -> o_valid=0, o_busy=0 without waiting for a clock edge; after release, no stale output appears and o_ready=1.
- LANES=4, NTT, a=0, b={-7,1,2,3}, tw=4193792 -> o_a={-7,1,2,3} (freeze enabled: {8380410,1,2,3}).
